// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-side FSM states and word/byte geometry.
package uart_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } tx_state_e;
endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO with first-word-fall-through read; depth 2**ADDR_W.
// UART_TX_FEEDER_LEVEL_EN adds a fill-level output derived from the pointers.
module uart_word_fifo #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
`ifdef UART_TX_FEEDER_LEVEL_EN
    output logic [ADDR_W:0]   level,
`endif
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign pop_data = mem[rd_ptr_q[ADDR_W-1:0]];

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers 32-bit words and launches them LSB byte first into a UART transmitter
// via tx_start/tx_busy. Define UART_TX_FEEDER_LEVEL_EN for level/overflow_sticky ports.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        sdata,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              empty,
`ifdef UART_TX_FEEDER_LEVEL_EN
    output logic [ADDR_W:0]   level,
    output logic              overflow_sticky,
`endif
    output logic              idle
);
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    tx_state_e             state_q, state_d;
    logic [WORD_W-1:0]     shreg_q, shreg_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]            sdata_q, sdata_d;
    logic                  tx_start_q, tx_start_d;
    logic                  pop;
    logic [WORD_W-1:0]     fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_word_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
`ifdef UART_TX_FEEDER_LEVEL_EN
        .level     (level),
`endif
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign empty    = fifo_empty;
    assign sdata    = sdata_q;
    assign tx_start = tx_start_q;
    assign idle     = fifo_empty && (state_q == S_IDLE) && !tx_busy;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        sdata_d    = sdata_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Launch only into an idle transmitter; otherwise keep waiting here.
                if (!tx_busy) begin
                    sdata_d    = shreg_q[7:0];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = {8'h00, shreg_q[WORD_W-1:8]};
                        idx_d   = idx_q + 1'b1;
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            sdata_q    <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            sdata_q    <= sdata_d;
            tx_start_q <= tx_start_d;
        end
    end

`ifdef UART_TX_FEEDER_LEVEL_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_sticky = overflow_q;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a tx_busy transmitter model and byte scoreboard.
// Define UART_TX_FEEDER_LEVEL_EN to also exercise level/overflow_sticky.
module tb_uart_tx_feeder;
    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  sdata;
    logic        tx_start;
    logic        tx_busy;
    logic        empty;
    logic        idle;
`ifdef UART_TX_FEEDER_LEVEL_EN
    logic [ADDR_W:0] level;
    logic            overflow_sticky;
`endif

    logic        force_busy;
    logic        model_busy;
    logic        pend;
    logic        prev_start;
    int          busy_cnt;
    int          busy_min;
    int          busy_max;
    byte unsigned obs_q[$];
    int          start_count;
    int          viol_busy;
    int          viol_double;
    logic [7:0]  last_exp;
    int          checks;
    int          errors;

    assign tx_busy = force_busy | model_busy;
    always #5 clk = ~clk;

    uart_tx_feeder #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .empty    (empty),
`ifdef UART_TX_FEEDER_LEVEL_EN
        .level           (level),
        .overflow_sticky (overflow_sticky),
`endif
        .idle     (idle)
    );

    // Transmitter model: busy rises the cycle after a tx_start and lasts busy_min..busy_max cycles.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            model_busy = 1'b0;
            busy_cnt   = 0;
            pend       = 1'b0;
            prev_start = 1'b0;
            obs_q.delete();
        end else begin
            if (tx_start) begin
                if (tx_busy) viol_busy++;
                if (prev_start) viol_double++;
                obs_q.push_back(sdata);
                start_count++;
            end
            if (pend) begin
                model_busy = 1'b1;
                busy_cnt   = $urandom_range(busy_max, busy_min);
                pend       = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_busy = 1'b0;
            end
            if (tx_start) pend = 1'b1;
            prev_start = tx_start;
        end
    end

    // One write attempt; starts and ends just after a rising edge.
    task automatic write_word(input logic [31:0] d, output bit accepted);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        accepted = wr_ready;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (sdata !== 8'h00) begin errors++; $display("FAIL reset_sdata: got %h expected 00", sdata); end
`ifdef UART_TX_FEEDER_LEVEL_EN
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        last_exp = 8'h00;
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        bit ok;
        int base, s0, vb, vd, lat;
        w = 32'h44332211;
        busy_min = 20; busy_max = 20;
        base = obs_q.size(); s0 = start_count; vb = viol_busy; vd = viol_double;
        @(posedge clk); #1;
        write_word(w, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", ok); end
        @(negedge clk);
        lat = 1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: got %b expected 0", empty); end
        while (!tx_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d cycles expected 3", lat); end
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_idle_timeout: got idle=%b expected 1", idle); end
        checks++; if (start_count - s0 != 4) begin errors++; $display("FAIL single_starts: got %0d expected 4", start_count - s0); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = w[8*i +: 8];
            checks++;
            if (obs_q.size() <= base + i) begin errors++; $display("FAIL single_byte%0d: got none expected %h", i, e); end
            else if (obs_q[base + i] !== e) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, obs_q[base + i], e); end
        end
        checks++; if (viol_busy != vb || viol_double != vd) begin errors++; $display("FAIL single_protocol: got busy_viol=%0d double=%0d expected 0", viol_busy - vb, viol_double - vd); end
        last_exp = w[31:24];
        $display("test_single_word: word %h latency %0d starts %0d", w, lat, start_count - s0);
    endtask

    task automatic test_back_to_back();
        byte unsigned exp[$];
        logic [31:0] d;
        bit ok;
        int accepted, base, s0;
        busy_min = 1; busy_max = 4;
        base = obs_q.size(); s0 = start_count;
        @(posedge clk); #1;
        force_busy = 1'b1;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            d = $urandom;
            write_word(d, ok);
            if (!ok) break;
            accepted++;
            for (int b = 0; b < 4; b++) exp.push_back(d[8*b +: 8]);
        end
        @(negedge clk);
        checks++; if (accepted != 9) begin errors++; $display("FAIL b2b_accepted: got %0d expected 9", accepted); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (start_count != s0) begin errors++; $display("FAIL b2b_no_start: got %0d expected 0", start_count - s0); end
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_idle(3000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_idle_timeout: got idle=%b expected 1", idle); end
        checks++; if (start_count - s0 != exp.size()) begin errors++; $display("FAIL b2b_starts: got %0d expected %0d", start_count - s0, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs_q.size() <= base + i) begin errors++; $display("FAIL b2b_byte%0d: got none expected %h", i, exp[i]); end
            else if (obs_q[base + i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, obs_q[base + i], exp[i]); end
        end
        if (exp.size() > 0) last_exp = exp[exp.size() - 1];
        $display("test_back_to_back: accepted %0d words, %0d bytes", accepted, start_count - s0);
    endtask

    task automatic test_stream();
        byte unsigned exp[$];
        logic [31:0] d;
        bit ok;
        int n, guard, base, s0, vb, vd;
        busy_min = 1; busy_max = 6;
        base = obs_q.size(); s0 = start_count; vb = viol_busy; vd = viol_double;
        @(posedge clk); #1;
        n = 0; guard = 0;
        while (n < 40 && guard < 5000) begin
            if ($urandom_range(3, 0) != 0) begin
                d = $urandom;
                write_word(d, ok);
                if (ok) begin
                    n++;
                    for (int b = 0; b < 4; b++) exp.push_back(d[8*b +: 8]);
                end
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        checks++; if (n != 40) begin errors++; $display("FAIL stream_words: got %0d expected 40", n); end
        wait_idle(6000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stream_idle_timeout: got idle=%b expected 1", idle); end
        checks++; if (start_count - s0 != exp.size()) begin errors++; $display("FAIL stream_starts: got %0d expected %0d", start_count - s0, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs_q.size() <= base + i) begin errors++; $display("FAIL stream_byte%0d: got none expected %h", i, exp[i]); end
            else if (obs_q[base + i] !== exp[i]) begin errors++; $display("FAIL stream_byte%0d: got %h expected %h", i, obs_q[base + i], exp[i]); end
        end
        checks++; if (viol_busy != vb || viol_double != vd) begin errors++; $display("FAIL stream_protocol: got busy_viol=%0d double=%0d expected 0", viol_busy - vb, viol_double - vd); end
        if (exp.size() > 0) last_exp = exp[exp.size() - 1];
        $display("test_stream: %0d words, %0d bytes emitted", n, start_count - s0);
    endtask

    task automatic test_stuck_busy();
        logic [31:0] w;
        bit ok;
        int base, s0;
        w = 32'hA5C30F96;
        busy_min = 2; busy_max = 2;
        base = obs_q.size(); s0 = start_count;
        @(posedge clk); #1;
        force_busy = 1'b1;
        write_word(w, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stuck_accept: got %b expected 1", ok); end
        repeat (30) @(negedge clk);
        checks++; if (start_count != s0) begin errors++; $display("FAIL stuck_no_start: got %0d expected 0", start_count - s0); end
        checks++; if (sdata !== last_exp) begin errors++; $display("FAIL stuck_sdata: got %h expected %h", sdata, last_exp); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stuck_empty: got %b expected 1", empty); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL stuck_idle: got %b expected 0", idle); end
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stuck_idle_timeout: got idle=%b expected 1", idle); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = w[8*i +: 8];
            checks++;
            if (obs_q.size() <= base + i) begin errors++; $display("FAIL stuck_byte%0d: got none expected %h", i, e); end
            else if (obs_q[base + i] !== e) begin errors++; $display("FAIL stuck_byte%0d: got %h expected %h", i, obs_q[base + i], e); end
        end
        last_exp = w[31:24];
        $display("test_stuck_busy: held %0d starts while busy, then %0d bytes", 0, start_count - s0);
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        int s0, s1, guard;
        busy_min = 20; busy_max = 20;
        s0 = start_count;
        @(posedge clk); #1;
        write_word(32'h8877_6655, ok);
        write_word(32'hCCBB_AA99, ok);
        guard = 0;
        while (start_count - s0 < 2 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (start_count - s0 != 2) begin errors++; $display("FAIL midrst_second_byte: got %0d starts expected 2", start_count - s0); end
        repeat (5) @(negedge clk);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL midrst_pre_empty: got %b expected 0", empty); end
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        checks++; if (sdata !== 8'h00) begin errors++; $display("FAIL midrst_sdata: got %h expected 00", sdata); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: got %b expected 0", tx_start); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", idle); end
        @(posedge clk); #3;
        rstn = 1'b1;
        s1 = start_count;
        repeat (40) @(negedge clk);
        checks++; if (start_count != s1) begin errors++; $display("FAIL midrst_no_start: got %0d expected 0", start_count - s1); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_post_empty: got %b expected 1", empty); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_post_idle: got %b expected 1", idle); end
        last_exp = 8'h00;
        $display("test_reset_mid_word: %0d starts after reset", start_count - s1);
    endtask

`ifdef UART_TX_FEEDER_LEVEL_EN
    task automatic test_level();
        bit ok;
        int s0;
        busy_min = 1; busy_max = 3;
        s0 = start_count;
        @(posedge clk); #1;
        checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL level_ovf_init: got %b expected 0", overflow_sticky); end
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_word($urandom, ok);
        @(negedge clk);
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL level_after5: got %0d expected 4", level); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) write_word($urandom, ok);
        @(negedge clk);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL level_full: got %0d expected 8", level); end
        checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL level_ovf_before: got %b expected 0", overflow_sticky); end
        @(posedge clk); #1;
        write_word($urandom, ok);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL level_push_full: got accepted=%b expected 0", ok); end
        @(negedge clk);
        checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL level_ovf_set: got %b expected 1", overflow_sticky); end
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_idle(3000, ok);
        checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL level_ovf_sticky: got %b expected 1", overflow_sticky); end
        checks++; if (start_count - s0 != 36) begin errors++; $display("FAIL level_starts: got %0d expected 36", start_count - s0); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL level_drained: got %0d expected 0", level); end
        $display("test_level: %0d bytes after overflow", start_count - s0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        start_count = 0; viol_busy = 0; viol_double = 0;
        force_busy = 1'b0; busy_min = 1; busy_max = 1;
        wr_valid = 1'b0; wr_data = '0;
        last_exp = 8'h00;
        test_reset();
`ifdef UART_TX_FEEDER_LEVEL_EN
        test_level();
`endif
        test_single_word();
        test_back_to_back();
        test_stream();
        test_stuck_busy();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
